// File: rtl/apb_master_arb.sv
// Two-port APB master: round-robin arbitration between two command ports, one-hot
// slave decode, SETUP/ACCESS sequencing, read capture, miss/timeout error reporting.
module apb_master_arb #(
    parameter int unsigned NUM_SLV = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic [1:0]            req_valid,
    input  logic [1:0]            req_write,
    input  logic [63:0]           req_addr,
    input  logic [63:0]           req_wdata,
    output logic [1:0]            req_ready,
    output logic [1:0]            rsp_done,
    output logic                  rsp_err,
    output logic [31:0]           rsp_rdata,
    output logic [31:0]           PADDR,
    output logic                  PWRITE,
    output logic [31:0]           PWDATA,
    output logic [NUM_SLV-1:0]    PSEL,
    output logic                  PENABLE,
    input  logic [NUM_SLV*32-1:0] PRDATA,
    input  logic [NUM_SLV-1:0]    PREADY
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    localparam int unsigned CW = $clog2(TIMEOUT) + 1;

    logic [1:0]    state_q, state_d;
    logic          gnt_q, gnt_d;
    logic          rr_q, rr_d;
    logic          write_q, write_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    idx_q, idx_d;
    logic          err_q, err_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          gnt;
    logic [31:0]   cmd_addr;
    logic          cmd_hit;
    logic          sel_ready;
    logic [31:0]   sel_rdata;

    // rr_q names the requester that wins when both are valid
    always_comb begin
        if (req_valid == 2'b11) begin
            gnt = rr_q;
        end else begin
            gnt = req_valid[1];
        end
        cmd_addr = gnt ? req_addr[63:32] : req_addr[31:0];
        cmd_hit  = (cmd_addr[31:16] == 16'h1000) && (32'(cmd_addr[15:12]) < NUM_SLV);
    end

    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        for (int unsigned i = 0; i < NUM_SLV; i++) begin
            if (idx_q == 4'(i)) begin
                sel_ready = PREADY[i];
                sel_rdata = PRDATA[32*i +: 32];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        rr_d    = rr_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        idx_d   = idx_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (|req_valid) begin
                    gnt_d   = gnt;
                    rr_d    = ~gnt;
                    write_d = req_write[gnt];
                    addr_d  = cmd_addr;
                    wdata_d = gnt ? req_wdata[63:32] : req_wdata[31:0];
                    idx_d   = cmd_addr[15:12];
                    if (cmd_hit) begin
                        state_d = ST_SETUP;
                    end else begin
                        state_d = ST_RESP;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end
                end
            end
            ST_SETUP: begin
                cnt_d   = '0;
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                cnt_d = cnt_q + CW'(1);
                if (sel_ready) begin
                    err_d   = 1'b0;
                    rdata_d = write_q ? '0 : sel_rdata;
                    state_d = ST_RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = ST_RESP;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= ST_IDLE;
            gnt_q   <= 1'b0;
            rr_q    <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            rr_q    <= rr_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    // req_ready is combinational in IDLE, so it is also masked while reset is held
    always_comb begin
        req_ready = '0;
        rsp_done  = '0;
        PSEL      = '0;
        PENABLE   = 1'b0;
        PADDR     = '0;
        PWRITE    = 1'b0;
        PWDATA    = '0;
        if ((state_q == ST_IDLE) && (|req_valid) && PRESETn) begin
            req_ready[gnt] = 1'b1;
        end
        if ((state_q == ST_SETUP) || (state_q == ST_ACCESS)) begin
            for (int unsigned i = 0; i < NUM_SLV; i++) begin
                PSEL[i] = (idx_q == 4'(i));
            end
            PENABLE = (state_q == ST_ACCESS);
            PADDR   = addr_q;
            PWRITE  = write_q;
            PWDATA  = wdata_q;
        end
        if (state_q == ST_RESP) begin
            rsp_done[gnt_q] = 1'b1;
        end
    end

    assign rsp_err   = (state_q == ST_RESP) && err_q;
    assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_apb_master_arb.sv
// Directed bench for apb_master_arb with four 4-register APB slave models
// whose PREADY follows PSEL&PENABLE by one cycle.
module tb_apb_master_arb;

    localparam int NS = 4;

    logic              PCLK = 1'b0;
    logic              PRESETn = 1'b0;
    logic              v0 = 1'b0, v1 = 1'b0, w0 = 1'b0, w1 = 1'b0;
    logic [31:0]       a0 = '0, a1 = '0, d0 = '0, d1 = '0;
    logic [1:0]        req_valid, req_write, req_ready, rsp_done;
    logic [63:0]       req_addr, req_wdata;
    logic              rsp_err, PWRITE, PENABLE;
    logic [31:0]       rsp_rdata, PADDR, PWDATA;
    logic [NS-1:0]     PSEL, PREADY, pready_q;
    logic [NS-1:0]     stall = '0, extra_rdy = '0;
    logic [NS*32-1:0]  PRDATA;
    logic [31:0]       sreg [NS][4];

    int errors = 0;
    int checks = 0;
    int viol = 0;
    logic        gq[$];
    logic [33:0] dq[$];

    assign req_valid = {v1, v0};
    assign req_write = {w1, w0};
    assign req_addr  = {a1, a0};
    assign req_wdata = {d1, d0};
    assign PREADY    = pready_q | extra_rdy;

    apb_master_arb #(.NUM_SLV(NS), .TIMEOUT(16)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_done(rsp_done),
        .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA),
        .PSEL(PSEL), .PENABLE(PENABLE),
        .PRDATA(PRDATA), .PREADY(PREADY)
    );

    always #5 PCLK = ~PCLK;

    always_comb begin
        PRDATA = '0;
        for (int i = 0; i < NS; i++) PRDATA[32*i +: 32] = sreg[i][PADDR[3:2]];
    end

    always @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            pready_q <= '0;
            for (int i = 0; i < NS; i++)
                for (int j = 0; j < 4; j++) sreg[i][j] <= 32'h5A000000 | 32'(i << 8) | 32'(j);
        end else begin
            for (int i = 0; i < NS; i++) begin
                pready_q[i] <= PSEL[i] & PENABLE & ~pready_q[i] & ~stall[i];
                if (PSEL[i] && PENABLE && pready_q[i] && PWRITE) sreg[i][PADDR[3:2]] <= PWDATA;
            end
        end
    end

    always @(negedge PCLK) begin
        if (req_ready != 2'b00) gq.push_back(req_ready[1]);
        if (rsp_done != 2'b00) dq.push_back({rsp_err, rsp_done[1], rsp_rdata});
        if ((PENABLE && PSEL == '0) || !$onehot0(PSEL)) viol++;
    end

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic set_req(input int r, input logic v, input logic wr,
                           input logic [31:0] a, input logic [31:0] d);
        if (r == 0) begin v0 = v; w0 = wr; a0 = a; d0 = d; end
        else        begin v1 = v; w1 = wr; a1 = a; d1 = d; end
    endtask

    task automatic xfer(input int r, input logic wr, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output bit tmo);
        int n = 0;
        int m = 0;
        set_req(r, 1'b1, wr, a, d);
        #1;
        while (req_ready[r] !== 1'b1 && n < 50) begin step(); #1; n++; end
        step();
        set_req(r, 1'b0, 1'b0, '0, '0);
        #1;
        while (rsp_done[r] !== 1'b1 && m < 50) begin step(); #1; m++; end
        tmo = (n >= 50) || (m >= 50);
        rd = rsp_rdata;
        step();
    endtask

    task automatic stream(input int r, input logic [31:0] base, input int cnt, output bit tmo);
        int n;
        tmo = 1'b0;
        for (int k = 0; k < cnt; k++) begin
            set_req(r, 1'b1, 1'b0, base + 32'(k * 4), '0);
            #1;
            n = 0;
            while (req_ready[r] !== 1'b1 && n < 60) begin @(posedge PCLK); #2; n++; end
            if (n >= 60) tmo = 1'b1;
            @(posedge PCLK);
            #1;
        end
        set_req(r, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic test_reset();
        PRESETn = 1'b0;
        repeat (2) @(posedge PCLK);
        #2;
        checks++;
        if ({req_ready, rsp_done, rsp_err, PENABLE, PWRITE} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got rdy=%b done=%b err=%b en=%b wr=%b, want all 0",
                     req_ready, rsp_done, rsp_err, PENABLE, PWRITE);
        end
        checks++;
        if (PSEL !== '0 || PADDR !== '0 || PWDATA !== '0 || rsp_rdata !== '0) begin
            errors++;
            $display("FAIL reset_bus: got psel=%b paddr=%h pwdata=%h rdata=%h, want 0",
                     PSEL, PADDR, PWDATA, rsp_rdata);
        end
        PRESETn = 1'b1;
        step();
    endtask

    task automatic test_write();
        set_req(0, 1'b1, 1'b1, 32'h10001008, 32'hDEADBEEF);
        #1;
        checks++;
        if (req_ready !== 2'b01 || PSEL !== '0) begin
            errors++;
            $display("FAIL wr_accept: got rdy=%b psel=%b, want 01 0000", req_ready, PSEL);
        end
        step();
        set_req(0, 1'b0, 1'b0, '0, '0);
        #1;
        checks++;
        if (PSEL !== 4'b0010 || PENABLE !== 1'b0 || PADDR !== 32'h10001008 ||
            PWRITE !== 1'b1 || PWDATA !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL wr_setup: got psel=%b en=%b addr=%h wr=%b wd=%h, want 0010 0 10001008 1 deadbeef",
                     PSEL, PENABLE, PADDR, PWRITE, PWDATA);
        end
        for (int c = 0; c < 2; c++) begin
            step();
            #1;
            checks++;
            if (PSEL !== 4'b0010 || PENABLE !== 1'b1 || PWDATA !== 32'hDEADBEEF || rsp_done !== 2'b00) begin
                errors++;
                $display("FAIL wr_access%0d: got psel=%b en=%b wd=%h done=%b, want 0010 1 deadbeef 00",
                         c, PSEL, PENABLE, PWDATA, rsp_done);
            end
        end
        step();
        #1;
        checks++;
        if (rsp_done !== 2'b01 || rsp_err !== 1'b0 || PSEL !== '0 || PENABLE !== 1'b0) begin
            errors++;
            $display("FAIL wr_done: got done=%b err=%b psel=%b en=%b, want 01 0 0000 0",
                     rsp_done, rsp_err, PSEL, PENABLE);
        end
        step();
        #1;
        checks++;
        if (rsp_done !== 2'b00 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL wr_idle: got done=%b err=%b, want 00 0", rsp_done, rsp_err);
        end
    endtask

    task automatic test_read();
        int n = 0;
        set_req(1, 1'b1, 1'b0, 32'h10001008, '0);
        #1;
        checks++;
        if (req_ready !== 2'b10) begin
            errors++;
            $display("FAIL rd_accept: got rdy=%b, want 10", req_ready);
        end
        step();
        set_req(1, 1'b0, 1'b0, '0, '0);
        #1;
        while (rsp_done !== 2'b10 && n < 20) begin step(); #1; n++; end
        checks++;
        if (n !== 3) begin
            errors++;
            $display("FAIL rd_latency: got done %0d cycles after SETUP, want 3", n);
        end
        checks++;
        if (rsp_rdata !== 32'hDEADBEEF || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL rd_data: got rdata=%h err=%b, want deadbeef 0", rsp_rdata, rsp_err);
        end
        step();
    endtask

    task automatic test_timeout();
        int n = 0;
        int pen = 0;
        int bad = 0;
        stall = 4'b0100;
        extra_rdy = 4'b0001;
        set_req(1, 1'b1, 1'b0, 32'h10002000, '0);
        #1;
        checks++;
        if (req_ready !== 2'b10) begin
            errors++;
            $display("FAIL to_accept: got rdy=%b, want 10", req_ready);
        end
        step();
        set_req(1, 1'b0, 1'b0, '0, '0);
        #1;
        while (rsp_done !== 2'b10 && n < 60) begin
            if (PENABLE === 1'b1) begin
                pen++;
                if (PSEL !== 4'b0100) bad++;
            end
            step();
            #1;
            n++;
        end
        checks++;
        if (pen !== 16 || bad !== 0) begin
            errors++;
            $display("FAIL to_penable: got %0d PENABLE cycles, %0d bad PSEL, want 16 and 0", pen, bad);
        end
        checks++;
        if (n !== 17 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL to_resp: got n=%0d err=%b rdata=%h, want 17 1 00000000", n, rsp_err, rsp_rdata);
        end
        stall = '0;
        extra_rdy = '0;
        step();
        set_req(0, 1'b1, 1'b0, 32'h00000000, '0);
        #1;
        checks++;
        if (req_ready !== 2'b01 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL to_idle: got rdy=%b err=%b, want 01 0", req_ready, rsp_err);
        end
        step();
        set_req(0, 1'b0, 1'b0, '0, '0);
        step();
    endtask

    task automatic test_decode_miss();
        logic [31:0] miss_addr [2];
        logic [31:0] rd;
        bit tmo;
        miss_addr[0] = 32'h20000000;
        miss_addr[1] = 32'h10004000;
        for (int k = 0; k < 2; k++) begin
            xfer(0, 1'b1, 32'h10000004, 32'h0BADF00D, rd, tmo);
            set_req(0, 1'b1, 1'b0, miss_addr[k], '0);
            #1;
            checks++;
            if (req_ready !== 2'b01 || PSEL !== '0) begin
                errors++;
                $display("FAIL miss_accept%0d: got rdy=%b psel=%b, want 01 0000", k, req_ready, PSEL);
            end
            step();
            set_req(0, 1'b0, 1'b0, '0, '0);
            #1;
            checks++;
            if (rsp_done !== 2'b01 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0 ||
                PSEL !== '0 || PENABLE !== 1'b0) begin
                errors++;
                $display("FAIL miss_resp%0d: got done=%b err=%b rdata=%h psel=%b en=%b, want 01 1 0 0000 0",
                         k, rsp_done, rsp_err, rsp_rdata, PSEL, PENABLE);
            end
            step();
        end
        xfer(1, 1'b0, 32'h10000004, '0, rd, tmo);
        checks++;
        if (tmo !== 1'b0 || rd !== 32'h0BADF00D) begin
            errors++;
            $display("FAIL miss_wr_then_rd: got tmo=%b rdata=%h, want 0 0badf00d", tmo, rd);
        end
    endtask

    task automatic test_round_robin();
        bit tmo0, tmo1;
        int g0, q0, n;
        logic [33:0] exp;
        PRESETn = 1'b0;
        step();
        step();
        PRESETn = 1'b1;
        step();
        g0 = gq.size();
        q0 = dq.size();
        fork
            stream(0, 32'h10000000, 4, tmo0);
            stream(1, 32'h10003000, 4, tmo1);
        join
        n = 0;
        while (dq.size() < q0 + 8 && n < 50) begin step(); n++; end
        repeat (3) step();
        checks++;
        if (tmo0 || tmo1 || gq.size() !== g0 + 8 || dq.size() !== q0 + 8) begin
            errors++;
            $display("FAIL rr_counts: got tmo=%b%b grants=%0d dones=%0d, want 00 8 8",
                     tmo0, tmo1, gq.size() - g0, dq.size() - q0);
        end else begin
            for (int k = 0; k < 8; k++) begin
                exp = {1'b0, (k % 2 == 1), ((k % 2 == 1) ? 32'h5A000300 : 32'h5A000000) + 32'(k / 2)};
                checks++;
                if (gq[g0 + k] !== exp[32] || dq[q0 + k] !== exp) begin
                    errors++;
                    $display("FAIL rr_seq%0d: got grant=%b done=%h, want grant=%b done=%h",
                             k, gq[g0 + k], dq[q0 + k], exp[32], exp);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        logic [31:0] rd;
        bit tmo;
        set_req(0, 1'b1, 1'b1, 32'h10003004, 32'h12345678);
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL rst_accept: got rdy=%b, want 01", req_ready);
        end
        step();
        step();
        #1;
        checks++;
        if (PENABLE !== 1'b1 || PSEL !== 4'b1000) begin
            errors++;
            $display("FAIL rst_pre: got en=%b psel=%b, want 1 1000", PENABLE, PSEL);
        end
        set_req(1, 1'b1, 1'b0, 32'h10000000, '0);
        PRESETn = 1'b0;
        #1;
        checks++;
        if (PSEL !== '0 || PENABLE !== 1'b0 || req_ready !== 2'b00) begin
            errors++;
            $display("FAIL rst_async: got psel=%b en=%b rdy=%b, want 0000 0 00", PSEL, PENABLE, req_ready);
        end
        repeat (3) begin
            step();
            #1;
            if (rsp_done !== 2'b00 || req_ready !== 2'b00) n++;
        end
        checks++;
        if (n !== 0) begin
            errors++;
            $display("FAIL rst_quiet: got %0d cycles with done/ready during reset, want 0", n);
        end
        PRESETn = 1'b1;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL rst_prio: got rdy=%b, want 01", req_ready);
        end
        step();
        set_req(0, 1'b0, 1'b0, '0, '0);
        #1;
        n = 0;
        while (rsp_done !== 2'b01 && n < 20) begin step(); #1; n++; end
        checks++;
        if (n !== 3 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL rst_reissue: got n=%0d err=%b, want 3 0", n, rsp_err);
        end
        step();
        #1;
        checks++;
        if (req_ready !== 2'b10) begin
            errors++;
            $display("FAIL rst_next: got rdy=%b, want 10", req_ready);
        end
        step();
        set_req(1, 1'b0, 1'b0, '0, '0);
        #1;
        n = 0;
        while (rsp_done !== 2'b10 && n < 20) begin step(); #1; n++; end
        checks++;
        if (rsp_rdata !== 32'h5A000000 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL rst_rd0: got rdata=%h err=%b, want 5a000000 0", rsp_rdata, rsp_err);
        end
        step();
        xfer(0, 1'b0, 32'h10003004, '0, rd, tmo);
        checks++;
        if (tmo !== 1'b0 || rd !== 32'h12345678) begin
            errors++;
            $display("FAIL rst_readback: got tmo=%b rdata=%h, want 0 12345678", tmo, rd);
        end
    endtask

    task automatic test_invariants();
        checks++;
        if (viol !== 0) begin
            errors++;
            $display("FAIL apb_invariant: got %0d cycles with bad PSEL/PENABLE, want 0", viol);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_decode_miss();
        test_round_robin();
        test_reset_mid();
        test_invariants();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
